rx_frame_gate: RTL and testbench

//  Flow controller for the shared rx sample buffer. Admits or drops each DDC frame-available event according to buffer occupancy.

---
 rtl/rx_frame_gate.sv | 160 ++++++++++++++++
 tb/tb_rx_frame_gate.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_gate.sv
// rx_frame_gate: admits or drops DDC frame events by buffer occupancy, starts the
// frame writer, tracks committed unread frames and aborts a stalled writer.
`default_nettype none

module rx_frame_gate #(
    parameter int DEPTH_FRAMES = 8,
    parameter int OCC_W        = 4,
    parameter int WD_CYCLES    = 4096,
    parameter int CNT_W        = 16
) (
    input  logic             adc_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             frame_req,
    input  logic             frame_wr_done,
    input  logic             frame_rd_done,
    input  logic             clear_stats,
    output logic             frame_go,
    output logic             abort,
    output logic             busy,
    output logic [OCC_W-1:0] occupancy,
    output logic             full,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic [CNT_W-1:0] frame_seq,
    output logic [2:0]       err_sticky
);

    localparam int WD_W = (WD_CYCLES > 2) ? $clog2(WD_CYCLES) : 1;
    localparam logic [WD_W-1:0]  c_wd_load = WD_W'(WD_CYCLES - 1);
    localparam logic [OCC_W-1:0] c_depth   = OCC_W'(DEPTH_FRAMES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           r_state, w_state_n;
    logic [WD_W-1:0]  r_wd, w_wd_n;
    logic             r_go, w_go_n;
    logic             r_abort, w_abort_n;
    logic [OCC_W-1:0] r_occ, w_occ_n;
    logic             r_full, w_full_n;
    logic [CNT_W-1:0] r_ovr, w_ovr_n;
    logic [CNT_W-1:0] r_seq, w_seq_n;
    logic [2:0]       r_err, w_err_n;

    logic             w_req;
    logic             w_commit;
    logic             w_drop;
    logic             w_rd_ok;
    logic [2:0]       w_err_new;

    assign w_req = frame_req & enable;

    always_comb begin
        w_state_n = r_state;
        w_wd_n    = r_wd;
        w_go_n    = 1'b0;
        w_abort_n = 1'b0;
        w_commit  = 1'b0;
        w_drop    = 1'b0;
        w_err_new = 3'b000;

        case (r_state)
            ST_IDLE: begin
                if (frame_wr_done) begin
                    w_err_new[2] = 1'b1;
                end
                if (w_req) begin
                    if (r_occ < c_depth) begin
                        w_go_n    = 1'b1;
                        w_state_n = ST_BUSY;
                        w_wd_n    = c_wd_load;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (w_req) begin
                    w_drop = 1'b1;
                end
                // A commit on the expiry cycle takes priority over the abort.
                if (frame_wr_done) begin
                    w_commit  = 1'b1;
                    w_state_n = ST_IDLE;
                end else if (r_wd == '0) begin
                    w_abort_n    = 1'b1;
                    w_err_new[0] = 1'b1;
                    w_state_n    = ST_IDLE;
                end else begin
                    w_wd_n = r_wd - 1'b1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase

        w_rd_ok = frame_rd_done & (r_occ != '0);
        if (frame_rd_done && (r_occ == '0)) begin
            w_err_new[1] = 1'b1;
        end

        w_occ_n = r_occ;
        if (w_commit && !w_rd_ok) begin
            w_occ_n = r_occ + 1'b1;
        end else if (!w_commit && w_rd_ok) begin
            w_occ_n = r_occ - 1'b1;
        end
        w_full_n = (w_occ_n == c_depth);

        w_seq_n = w_commit ? (r_seq + 1'b1) : r_seq;

        w_ovr_n = clear_stats ? '0 : r_ovr;
        if (w_drop) begin
            if (clear_stats) begin
                w_ovr_n = CNT_W'(1);
            end else if (r_ovr != '1) begin
                w_ovr_n = r_ovr + 1'b1;
            end
        end

        w_err_n = (clear_stats ? 3'b000 : r_err) | w_err_new;
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_wd    <= '0;
            r_go    <= 1'b0;
            r_abort <= 1'b0;
            r_occ   <= '0;
            r_full  <= 1'b0;
            r_ovr   <= '0;
            r_seq   <= '0;
            r_err   <= 3'b000;
        end else begin
            r_state <= w_state_n;
            r_wd    <= w_wd_n;
            r_go    <= w_go_n;
            r_abort <= w_abort_n;
            r_occ   <= w_occ_n;
            r_full  <= w_full_n;
            r_ovr   <= w_ovr_n;
            r_seq   <= w_seq_n;
            r_err   <= w_err_n;
        end
    end

    assign frame_go    = r_go;
    assign abort       = r_abort;
    assign busy        = (r_state == ST_BUSY);
    assign occupancy   = r_occ;
    assign full        = r_full;
    assign overrun_cnt = r_ovr;
    assign frame_seq   = r_seq;
    assign err_sticky  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rx_frame_gate.sv
// tb_rx_frame_gate: directed scenarios for rx_frame_gate with hand-computed expectations.
`default_nettype none

module tb_rx_frame_gate;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        frame_req;
    logic        frame_wr_done;
    logic        frame_rd_done;
    logic        clear_stats;
    logic        frame_go;
    logic        abort;
    logic        busy;
    logic [3:0]  occupancy;
    logic        full;
    logic [15:0] overrun_cnt;
    logic [15:0] frame_seq;
    logic [2:0]  err_sticky;

    int checks = 0;
    int passed = 0;
    int exp_seq = 0;

    rx_frame_gate #(
        .DEPTH_FRAMES(8),
        .OCC_W       (4),
        .WD_CYCLES   (16),
        .CNT_W       (16)
    ) dut (
        .adc_clk      (clk),
        .reset        (reset),
        .enable       (enable),
        .frame_req    (frame_req),
        .frame_wr_done(frame_wr_done),
        .frame_rd_done(frame_rd_done),
        .clear_stats  (clear_stats),
        .frame_go     (frame_go),
        .abort        (abort),
        .busy         (busy),
        .occupancy    (occupancy),
        .full         (full),
        .overrun_cnt  (overrun_cnt),
        .frame_seq    (frame_seq),
        .err_sticky   (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One admitted frame: request, then a commit on the following cycle.
    task automatic run_frame();
        frame_req = 1'b1; tick(); frame_req = 1'b0;
        frame_wr_done = 1'b1; tick(); frame_wr_done = 1'b0;
        exp_seq++;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; frame_req = 1'b0; frame_wr_done = 1'b0;
        frame_rd_done = 1'b0; clear_stats = 1'b0;
        tick(); tick();
        checks++; if ({frame_go, abort, busy, full} !== 4'b0000) $display("FAIL reset_flags: got %b exp 0000", {frame_go, abort, busy, full}); else passed++;
        checks++; if (occupancy !== 4'd0 || frame_seq !== 16'd0) $display("FAIL reset_occ_seq: got %0d/%0d exp 0/0", occupancy, frame_seq); else passed++;
        checks++; if (overrun_cnt !== 16'd0 || err_sticky !== 3'b000) $display("FAIL reset_stats: got %0d/%b exp 0/000", overrun_cnt, err_sticky); else passed++;
        reset = 1'b0; enable = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        frame_req = 1'b1; tick(); frame_req = 1'b0;
        checks++; if (frame_go !== 1'b1 || busy !== 1'b1) $display("FAIL basic_go: got go=%b busy=%b exp 1/1", frame_go, busy); else passed++;
        tick();
        checks++; if (frame_go !== 1'b0 || busy !== 1'b1) $display("FAIL basic_go_pulse: got go=%b busy=%b exp 0/1", frame_go, busy); else passed++;
        tick(); tick();
        frame_wr_done = 1'b1; tick(); frame_wr_done = 1'b0;
        exp_seq++;
        checks++; if (occupancy !== 4'd1 || frame_seq !== 16'd1 || busy !== 1'b0) $display("FAIL basic_commit: got occ=%0d seq=%0d busy=%b exp 1/1/0", occupancy, frame_seq, busy); else passed++;
        frame_rd_done = 1'b1; tick(); frame_rd_done = 1'b0;
        checks++; if (occupancy !== 4'd0) $display("FAIL basic_read: got occ=%0d exp 0", occupancy); else passed++;
    endtask

    task automatic test_full();
        int gos;
        for (int i = 0; i < 8; i++) run_frame();
        checks++; if (full !== 1'b1 || occupancy !== 4'd8) $display("FAIL full_set: got full=%b occ=%0d exp 1/8", full, occupancy); else passed++;
        gos = 0;
        for (int i = 0; i < 3; i++) begin
            frame_req = 1'b1; tick(); frame_req = 1'b0;
            if (frame_go === 1'b1 || busy === 1'b1) gos++;
            tick();
        end
        checks++; if (overrun_cnt !== 16'd3 || gos !== 0) $display("FAIL full_drop: got ovr=%0d starts=%0d exp 3/0", overrun_cnt, gos); else passed++;
        frame_rd_done = 1'b1; tick(); frame_rd_done = 1'b0;
        checks++; if (full !== 1'b0 || occupancy !== 4'd7) $display("FAIL full_read: got full=%b occ=%0d exp 0/7", full, occupancy); else passed++;
        frame_req = 1'b1; tick(); frame_req = 1'b0;
        checks++; if (frame_go !== 1'b1) $display("FAIL full_readmit: got go=%b exp 1", frame_go); else passed++;
        frame_wr_done = 1'b1; tick(); frame_wr_done = 1'b0;
        exp_seq++;
        checks++; if (frame_seq !== 16'(exp_seq) || full !== 1'b1) $display("FAIL full_seq: got seq=%0d full=%b exp %0d/1", frame_seq, full, exp_seq); else passed++;
        frame_rd_done = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        frame_rd_done = 1'b0;
        clear_stats = 1'b1; tick(); clear_stats = 1'b0;
        checks++; if (overrun_cnt !== 16'd0 || err_sticky !== 3'b000 || occupancy !== 4'd0) $display("FAIL clear_stats: got ovr=%0d err=%b occ=%0d exp 0/000/0", overrun_cnt, err_sticky, occupancy); else passed++;
    endtask

    task automatic test_back_to_back();
        int gos;
        gos = 0;
        frame_req = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (frame_go === 1'b1) gos++;
        end
        frame_req = 1'b0;
        frame_wr_done = 1'b1; tick(); frame_wr_done = 1'b0;
        exp_seq++;
        checks++; if (gos !== 1 || overrun_cnt !== 16'd10) $display("FAIL b2b: got starts=%0d ovr=%0d exp 1/10", gos, overrun_cnt); else passed++;
        frame_rd_done = 1'b1; tick(); frame_rd_done = 1'b0;
        clear_stats = 1'b1; tick(); clear_stats = 1'b0;
    endtask

    task automatic test_watchdog();
        int n;
        n = 0;
        frame_req = 1'b1; tick(); frame_req = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (abort === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++; if (n !== 16) $display("FAIL wd_latency: got %0d cycles exp 16", n); else passed++;
        checks++; if (err_sticky !== 3'b001 || occupancy !== 4'd0 || busy !== 1'b0) $display("FAIL wd_state: got err=%b occ=%0d busy=%b exp 001/0/0", err_sticky, occupancy, busy); else passed++;
        tick();
        checks++; if (abort !== 1'b0) $display("FAIL wd_pulse: got abort=%b exp 0", abort); else passed++;
        clear_stats = 1'b1; tick(); clear_stats = 1'b0;
        frame_req = 1'b1; tick(); frame_req = 1'b0;
        for (int i = 1; i <= 15; i++) tick();
        frame_wr_done = 1'b1; tick(); frame_wr_done = 1'b0;
        exp_seq++;
        checks++; if (abort !== 1'b0 || occupancy !== 4'd1 || err_sticky !== 3'b000) $display("FAIL wd_commit_wins: got abort=%b occ=%0d err=%b exp 0/1/000", abort, occupancy, err_sticky); else passed++;
        frame_rd_done = 1'b1; tick(); frame_rd_done = 1'b0;
    endtask

    task automatic test_boundary();
        run_frame(); run_frame();
        frame_req = 1'b1; tick(); frame_req = 1'b0;
        frame_wr_done = 1'b1; frame_rd_done = 1'b1; tick();
        frame_wr_done = 1'b0; frame_rd_done = 1'b0;
        exp_seq++;
        checks++; if (occupancy !== 4'd2 || frame_seq !== 16'(exp_seq)) $display("FAIL commit_read: got occ=%0d seq=%0d exp 2/%0d", occupancy, frame_seq, exp_seq); else passed++;
        frame_rd_done = 1'b1; tick(); tick(); tick(); frame_rd_done = 1'b0;
        checks++; if (occupancy !== 4'd0 || err_sticky !== 3'b010) $display("FAIL underflow: got occ=%0d err=%b exp 0/010", occupancy, err_sticky); else passed++;
        frame_wr_done = 1'b1; tick(); frame_wr_done = 1'b0;
        checks++; if (err_sticky !== 3'b110 || busy !== 1'b0 || occupancy !== 4'd0) $display("FAIL idle_wr_done: got err=%b busy=%b occ=%0d exp 110/0/0", err_sticky, busy, occupancy); else passed++;
        clear_stats = 1'b1; frame_rd_done = 1'b1; tick();
        clear_stats = 1'b0; frame_rd_done = 1'b0;
        checks++; if (err_sticky !== 3'b010) $display("FAIL clear_vs_err: got err=%b exp 010", err_sticky); else passed++;
        clear_stats = 1'b1; tick(); clear_stats = 1'b0;
        checks++; if (err_sticky !== 3'b000 || frame_seq !== 16'(exp_seq)) $display("FAIL clear_keeps_seq: got err=%b seq=%0d exp 000/%0d", err_sticky, frame_seq, exp_seq); else passed++;
    endtask

    task automatic test_enable_and_reset();
        int aborts;
        enable = 1'b0;
        frame_req = 1'b1; tick(); frame_req = 1'b0;
        checks++; if (frame_go !== 1'b0 || busy !== 1'b0 || overrun_cnt !== 16'd0) $display("FAIL disabled_req: got go=%b busy=%b ovr=%0d exp 0/0/0", frame_go, busy, overrun_cnt); else passed++;
        enable = 1'b1;
        frame_req = 1'b1; tick(); frame_req = 1'b0;
        enable = 1'b0;
        tick();
        frame_wr_done = 1'b1; tick(); frame_wr_done = 1'b0;
        exp_seq++;
        checks++; if (occupancy !== 4'd1 || frame_seq !== 16'(exp_seq)) $display("FAIL disable_midbusy: got occ=%0d seq=%0d exp 1/%0d", occupancy, frame_seq, exp_seq); else passed++;
        enable = 1'b1;
        frame_req = 1'b1; tick(); frame_req = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (busy !== 1'b0 || abort !== 1'b0 || occupancy !== 4'd0 || frame_seq !== 16'd0) $display("FAIL reset_midbusy: got busy=%b abort=%b occ=%0d seq=%0d exp 0/0/0/0", busy, abort, occupancy, frame_seq); else passed++;
        aborts = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (abort === 1'b1) aborts++;
        end
        checks++; if (aborts !== 0 || err_sticky !== 3'b000) $display("FAIL reset_no_abort: got aborts=%0d err=%b exp 0/000", aborts, err_sticky); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_watchdog();
        test_boundary();
        test_enable_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
